uart_tx_block: RTL
==================

# uart_tx_block

Serial transmitter for the UART link: accepts a byte on a single-cycle start strobe and shifts it out as an 8N1 frame on `serial_out`, one bit every `CLKS_PER_BIT` clocks. It is the transmitting end of the lab's UART receive path and runs at the same bit rate and framing. It exposes busy/done status so a host FSM or FIFO can pace writes.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit; legal range 2..1023.
- `DATA_BITS`, default 8: payload width; legal range 5..8.

- `clk`  in  1  clock, rising-edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `tx_start`  in  1  request to send `tx_data`; honoured only when idle.
- `tx_data`  in  DATA_BITS  payload, captured on an accepted `tx_start`.
- `serial_out`  out  1  serial line, idle high; registered.
- `tx_busy`  out  1  high from acceptance through the end of the stop bit.
- `tx_done`  out  1  one-cycle pulse after the stop bit completes.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE: `serial_out`=1, `tx_busy`=0. If `tx_start`=1 at a rising edge, then `tx_data` is latched into the shift register, the bit timer clears, and the state moves to START.
- START: `serial_out`=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: `serial_out`=shift_reg[0], so data goes out LSB first. At each bit-period end the register shifts right and the index increments. After bit DATA_BITS-1 the state moves to STOP.
- STOP: `serial_out`=1 for CLKS_PER_BIT cycles. It then returns to IDLE and pulses `tx_done` for one cycle.
- `tx_start` outside IDLE is ignored, with no queuing.
- Changes to `tx_data` after acceptance have no effect on the frame in flight.
- Timer width is $clog2(CLKS_PER_BIT). The period ends when count == CLKS_PER_BIT-1, and the count wraps to 0. Bit index width is 4.
- Reset values: `serial_out`=1, `tx_busy`=0, `tx_done`=0, state IDLE, timer 0, shift register 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronous). `serial_out` returns high with no stop bit and no `tx_done`.

## Timing
- Let edge E0 be the edge that samples `tx_start`=1 in IDLE.
- After E0: `serial_out`=0 and `tx_busy`=1.
- Data bit i is driven after edge E0+(1+i)·C and held for C cycles, where C=CLKS_PER_BIT.
- Stop bit is driven after edge E0+(1+DATA_BITS)·C.
- After edge E0+(2+DATA_BITS)·C: state IDLE, `tx_busy`=0, `tx_done`=1 for exactly one cycle.
- Frame length is (2+DATA_BITS)·C cycles, which is 100 cycles at the defaults.
- `tx_start` is accepted again at the first edge where the state is IDLE, i.e. the edge that ends the `tx_done` cycle.
- Minimum start-to-start spacing is (2+DATA_BITS)·C+1 cycles.
- `tx_start` held high continuously produces back-to-back frames separated by one idle-high cycle.

## Structure
- Package `uart_tx_pkg` holds:
  - `tx_state_t` enum: IDLE, START, DATA, STOP.
  - Constants `START_BIT`=1'b0, `STOP_BIT`=1'b1, `IDLE_LEVEL`=1'b1.
- Sub-module `tx_bit_timer`:
  - Parameterised on CLKS_PER_BIT.
  - Inputs `clk`, `n_rst`, `enable`, `clear`; output `bit_end`.
  - `bit_end` pulses on the last cycle of each bit period while enabled.
  - `clear` has priority and forces the count to 0.
- The top level contains the FSM, shift register and bit index.

## Test plan
- Reset then idle: `n_rst` low then high, no start for 50 cycles → `serial_out`=1, `tx_busy`=0, `tx_done`=0 throughout.
- Single frame: `tx_data`=8'hA5 with a 1-cycle `tx_start` → `serial_out` carries 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles wide. `tx_done` pulses exactly 100 cycles after acceptance, with `tx_busy` high for those 100 cycles.
- Ignored start: during frame 8'h3C, pulse `tx_start` with `tx_data`=8'hFF at cycle 40 → frame 8'h3C completes unchanged and no second frame follows.
- Back-to-back: `tx_start` held high with `tx_data`=8'h00 then 8'hFF → two frames with exactly one idle-high cycle between them, and two `tx_done` pulses 101 cycles apart.
- Reset mid-frame: assert `n_rst` at cycle 55 of a frame → `serial_out`=1 asynchronously, `tx_busy`=0, no `tx_done`. A new 8'h81 frame sent after release is correct.
- Parameter sweep: CLKS_PER_BIT=2 and 16, DATA_BITS=5 → bit widths and a frame length of (2+DATA_BITS)·C match exactly.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmitter.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int IDX_W = 4;

endpackage : uart_tx_pkg

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last one.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic clear,
  output logic bit_end
);

  // A period of one clock would need a zero-width counter; keep at least one bit.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] count;

  // Cycle counter: clear wins, otherwise count while enabled and wrap at the period end.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (count == LAST) begin
        count <= '0;
      end else begin
        count <= count + TW'(1);
      end
    end else begin
      count <= count;
    end
  end

  assign bit_end = enable && !clear && (count == LAST);

endmodule : tx_bit_timer

// File: rtl/uart_tx_block.sv
// UART transmitter: sends one 8N1-style frame (DATA_BITS payload) per accepted start strobe.
module uart_tx_block
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  tx_state_t            state;
  tx_state_t            state_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     idx_next;
  logic                 serial_next;
  logic                 busy_next;
  logic                 done_next;
  logic                 timer_clear;
  logic                 timer_enable;
  logic                 bit_end;

  assign timer_enable = (state != IDLE);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .enable (timer_enable),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  // State, datapath and registered line/status outputs; reset aborts any frame at once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= '0;
      serial_out <= IDLE_LEVEL;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      bit_idx    <= idx_next;
      serial_out <= serial_next;
      tx_busy    <= busy_next;
      tx_done    <= done_next;
    end
  end

  // Next-state logic; the line level is derived from the upcoming state so it is registered.
  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    idx_next    = bit_idx;
    timer_clear = 1'b0;
    done_next   = 1'b0;
    serial_next = IDLE_LEVEL;
    busy_next   = 1'b0;

    case (state)
      IDLE: begin
        if (tx_start) begin
          state_next  = START;
          shift_next  = tx_data;
          idx_next    = '0;
          timer_clear = 1'b1;
        end else begin
          state_next  = IDLE;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          idx_next   = '0;
        end else begin
          state_next = START;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == LAST_IDX) begin
            state_next = STOP;
          end else begin
            shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
            idx_next   = bit_idx + IDX_W'(1);
          end
        end else begin
          state_next = DATA;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          state_next = STOP;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    case (state_next)
      IDLE:    serial_next = IDLE_LEVEL;
      START:   serial_next = START_BIT;
      DATA:    serial_next = shift_next[0];
      STOP:    serial_next = STOP_BIT;
      default: serial_next = IDLE_LEVEL;
    endcase

    if (state_next != IDLE) begin
      busy_next = 1'b1;
    end else begin
      busy_next = 1'b0;
    end
  end

endmodule : uart_tx_block
